booth_seq_ctrl: RTL and testbench



---
 rtl/booth_pkg.sv | 33 +++
 rtl/booth_addend_gen.sv | 32 +++
 rtl/booth_seq_ctrl.sv | 143 ++++++++++++++
 tb/tb_booth_seq_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// booth_pkg: shared types and constants for the sequential Booth multiplier.
//   BOOTH_W   default operand width
//   BOOTH_PW  product / shared adder width (2 * BOOTH_W)
//   state_e   controller states (IDLE, RUN, DONE)
//   recode_e  radix-2 Booth recoding of one multiplier bit pair (NOP, ADD, SUB)
//   booth_recode() maps {Q[i], q_prev} to a recode action.
package booth_pkg;

    localparam int BOOTH_W  = 7;
    localparam int BOOTH_PW = 2 * BOOTH_W;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    typedef enum logic [1:0] {
        NOP,
        ADD,
        SUB
    } recode_e;

    // {Q[i], q_prev}: 01 -> +M, 10 -> -M, 00/11 -> no adder use.
    function automatic recode_e booth_recode(input logic q_bit, input logic q_prev);
        case ({q_bit, q_prev})
            2'b01:   return ADD;
            2'b10:   return SUB;
            default: return NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_addend_gen.sv
// booth_addend_gen: combinational addend selection for the shared adder.
//   m       in  W    multiplicand M (signed)
//   neg_m   in  2W   precomputed -sext(M), 2W-bit two's complement
//   idx     in  IW   current multiplier bit position i
//   rec     in       recode action for this iteration
//   addend  out 2W   (sext(M) << i), (-M << i) or 0
module booth_addend_gen
    import booth_pkg::*;
#(
    parameter int W = BOOTH_W
) (
    input  logic [W-1:0]                         m,
    input  logic [2*W-1:0]                       neg_m,
    input  logic [((W > 1) ? $clog2(W) : 1)-1:0] idx,
    input  recode_e                              rec,
    output logic [2*W-1:0]                       addend
);

    logic [2*W-1:0] m_ext;

    assign m_ext = {{W{m[W-1]}}, m};

    always_comb begin
        addend = '0;
        case (rec)
            ADD:     addend = m_ext << idx;
            SUB:     addend = neg_m << idx;
            default: addend = '0;
        endcase
    end

endmodule

// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: iterative radix-2 Booth multiplier controller. Scans the
// multiplier one bit per cycle and time-shares a single 2W-bit adder, using it
// only on cycles where the recoding asks for +M or -M.
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand handshake (in_ready only in IDLE)
//   mcand, mplier         signed W-bit operands, sampled on the accepting edge
//   out_valid / out_ready product handshake (out_valid held until accepted)
//   product               signed 2W-bit result, held until the next DONE
//   busy                  high in RUN or DONE
//   add_cnt               adder operations used for the current/last product
// Build option: define BOOTH_EARLY_TERM_EN to leave RUN as soon as the
// remaining multiplier bits cannot trigger another add (latency 1..W).
module booth_seq_ctrl
    import booth_pkg::*;
#(
    parameter int W = BOOTH_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     mcand,
    input  logic [W-1:0]     mplier,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   product,
    output logic             busy,
    output logic [3:0]       add_cnt
);

    localparam int PW = 2 * W;
    localparam int IW = (W > 1) ? $clog2(W) : 1;
    localparam logic [IW-1:0] LAST_I = IW'(W - 1);

    state_e          state, state_nxt;
    logic [W-1:0]    m_r, q_r;
    logic [PW-1:0]   neg_m_r, p_r, prod_r;
    logic [IW-1:0]   idx;
    logic            q_prev;
    logic [3:0]      cnt_r;

    recode_e         rec;
    logic [PW-1:0]   m_ext, addend, add_a, sum, p_nxt;
    logic            last_iter;

    assign m_ext = {{W{mcand[W-1]}}, mcand};
    assign rec   = booth_recode(q_r[idx], q_prev);

    booth_addend_gen #(.W(W)) u_addend (
        .m      (m_r),
        .neg_m  (neg_m_r),
        .idx    (idx),
        .rec    (rec),
        .addend (addend)
    );

    // Shared adder: both operands forced to zero on NOP cycles so it stays quiet.
    // Carry-out is dropped; sums wrap mod 2^PW.
    assign add_a = (rec == NOP) ? '0 : p_r;
    assign sum   = add_a + addend;
    assign p_nxt = (rec == NOP) ? p_r : sum;

`ifdef BOOTH_EARLY_TERM_EN
    // Once every bit from i upward equals q_prev, all remaining pairs are 00/11.
    logic [W-1:0] hi_mask;
    logic         tail_flat;
    assign hi_mask   = {W{1'b1}} << idx;
    assign tail_flat = ((q_r ^ {W{q_prev}}) & hi_mask) == '0;
    assign last_iter = (idx == LAST_I) || tail_flat;
`else
    assign last_iter = (idx == LAST_I);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (last_iter) state_nxt = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                // A same-cycle in_valid is not taken here; IDLE accepts it next cycle.
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_r     <= '0;
            q_r     <= '0;
            neg_m_r <= '0;
            p_r     <= '0;
            prod_r  <= '0;
            idx     <= '0;
            q_prev  <= 1'b0;
            cnt_r   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        m_r     <= mcand;
                        q_r     <= mplier;
                        // Negate at full 2W width so -2^(W-1) becomes +2^(W-1).
                        neg_m_r <= -m_ext;
                        p_r     <= '0;
                        idx     <= '0;
                        q_prev  <= 1'b0;
                        cnt_r   <= '0;
                    end
                end
                RUN: begin
                    p_r    <= p_nxt;
                    q_prev <= q_r[idx];
                    idx    <= idx + 1'b1;
                    if (rec != NOP) cnt_r <= cnt_r + 1'b1;
                    // product only moves on entry to DONE, so it is held otherwise.
                    if (last_iter) prod_r <= p_nxt;
                end
                default: ;
            endcase
        end
    end

    assign product = prod_r;
    assign add_cnt = cnt_r;

endmodule

// File: tb/tb_booth_seq_ctrl.sv
// tb_booth_seq_ctrl: scoreboard bench for booth_seq_ctrl. A driver pushes the
// expected product / add count / latency per accepted pair; a monitor pops and
// compares on every output handshake and checks product stability.
module tb_booth_seq_ctrl;
    import booth_pkg::*;

    localparam int W  = BOOTH_W;
    localparam int PW = BOOTH_PW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [W-1:0]  mcand = '0;
    logic [W-1:0]  mplier = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [PW-1:0] product;
    logic          busy;
    logic [3:0]    add_cnt;

    booth_seq_ctrl #(.W(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcand     (mcand),
        .mplier    (mplier),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .product   (product),
        .busy      (busy),
        .add_cnt   (add_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [PW-1:0] prod;
        int            cnt;
        int            lat;
        int            acc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   last_hs = 0;
    int   rdy_mode = 0;
    bit   chk_b2b = 1'b0;
    bit   b2b_armed = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string nm);
        n_tests++;
        n_fail++;
        $display("FAIL %s (t=%0t)", nm, $time);
    endtask

    // Reference model: plain signed arithmetic and bit-transition counting.
    function automatic logic [PW-1:0] ref_prod(input logic [W-1:0] a, input logic [W-1:0] b);
        int ai, bi, pr;
        ai = int'($signed(a));
        bi = int'($signed(b));
        pr = ai * bi;
        return PW'(pr);
    endfunction

    function automatic int ref_cnt(input logic [W-1:0] b);
        int   c = 0;
        logic prev = 1'b0;
        for (int j = 0; j < W; j++) begin
            if (b[j] != prev) c++;
            prev = b[j];
        end
        return c;
    endfunction

    function automatic int ref_lat(input logic [W-1:0] b);
        int et = W;
        for (int i = W - 1; i >= 0; i--) begin
            logic prev = (i == 0) ? 1'b0 : b[i-1];
            bit   flat = 1'b1;
            for (int j = i; j < W; j++) if (b[j] != prev) flat = 1'b0;
            if (flat) et = i + 1;
        end
`ifdef BOOTH_EARLY_TERM_EN
        return et;
`else
        return (et > 0) ? W : W;
`endif
    endfunction

    task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        bit   done = 1'b0;
        in_valid = 1'b1;
        mcand    = a;
        mplier   = b;
        for (int k = 0; k < 300 && !done; k++) begin
            @(negedge clk);
            if (in_ready && rst_n) begin
                e.prod = ref_prod(a, b);
                e.cnt  = ref_cnt(b);
                e.lat  = ref_lat(b);
                e.acc  = cyc + 1;
                if (chk_b2b && b2b_armed) check("b2b_accept_cycle", e.acc, last_hs + 1);
                b2b_armed = chk_b2b;
                sb.push_back(e);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                // Scramble operands after the accepting edge; they must not matter.
                mcand    = W'($urandom);
                mplier   = W'($urandom);
                done     = 1'b1;
            end
        end
        if (!done) begin
            fail_now("accept_timeout");
            in_valid = 1'b0;
        end
    endtask

    task automatic drain();
        bit empty = 1'b0;
        for (int k = 0; k < 400 && !empty; k++) begin
            @(posedge clk);
            #2;
            if (sb.size() == 0) empty = 1'b1;
        end
        if (!empty) fail_now("drain_timeout");
    endtask

    task automatic wait_valid();
        bit seen = 1'b0;
        for (int k = 0; k < 50 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1'b1;
        end
        if (!seen) fail_now("out_valid_timeout");
    endtask

    function automatic logic [W-1:0] rand_op();
        int r = $urandom_range(0, 9);
        logic [W-1:0] v = W'($urandom);
        if (r == 0) v = {1'b1, {(W-1){1'b0}}};
        if (r == 1) v = {1'b0, {(W-1){1'b1}}};
        if (r == 2) v = '0;
        if (r == 3) v = '1;
        return v;
    endfunction

    // Sole driver of out_ready; mode 0 = low, 1 = high, 2 = random.
    initial begin
        forever begin
            @(posedge clk);
            #3;
            case (rdy_mode)
                0:       out_ready = 1'b0;
                1:       out_ready = 1'b1;
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
        end
    end

    // Monitor: latency on out_valid rise, stability while held, values on handshake.
    initial begin
        logic          prev_ov = 1'b0;
        logic [PW-1:0] prev_prod = '0;
        exp_t          e;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                prev_ov = 1'b0;
            end else begin
                if (out_valid && !prev_ov) begin
                    if (sb.size() == 0) fail_now("spurious_out_valid");
                    else check("latency", cyc - sb[0].acc, sb[0].lat);
                end
                if (out_valid && prev_ov) check("product_stable", product, prev_prod);
                if (out_valid && out_ready && sb.size() != 0) begin
                    e = sb.pop_front();
                    check("product", product, e.prod);
                    check("add_cnt", add_cnt, e.cnt);
                    last_hs = cyc + 1;
                end
                prev_ov   = out_valid;
                prev_prod = product;
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_product", product, 0);
        check("rst_add_cnt", add_cnt, 0);
        rst_n    = 1'b1;
        rdy_mode = 1;
        @(posedge clk);
        #1;

        send(7'd3, 7'd5);
        drain();
        check("3x5_product", product, 14'h000F);
        check("3x5_add_cnt", add_cnt, 4);

        send(7'h40, 7'h40);
        drain();
        check("m64xm64_product", product, 14'h1000);

        rdy_mode = 0;
        @(posedge clk);
        #1;
        send(7'h40, 7'd63);
        wait_valid();
        repeat (5) begin
            @(posedge clk);
            #1;
        end
        check("hold_out_valid", out_valid, 1);
        check("hold_product", product, 14'h3040);
        rdy_mode = 1;
        drain();
        check("post_hs_out_valid", out_valid, 0);
        check("post_hs_product_held", product, 14'h3040);
        check("post_hs_add_cnt", add_cnt, 2);

        send(7'd17, 7'd0);
        drain();
        check("17x0_product", product, 0);
        check("17x0_add_cnt", add_cnt, 0);

        send(7'd9, 7'd9);
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        rst_n = 1'b0;
        #1;
        check("midrun_rst_in_ready", in_ready, 1);
        check("midrun_rst_out_valid", out_valid, 0);
        check("midrun_rst_busy", busy, 0);
        check("midrun_rst_product", product, 0);
        check("midrun_rst_add_cnt", add_cnt, 0);
        sb.delete();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        send(7'd2, 7'h7D);
        drain();
        check("2xm3_product", product, 14'h3FFA);

        chk_b2b = 1'b1;
        send(7'd5, 7'd6);
        send(7'd7, 7'h7E);
        for (int n = 0; n < 500; n++) send(rand_op(), rand_op());
        drain();
        chk_b2b = 1'b0;

        rdy_mode = 2;
        for (int n = 0; n < 500; n++) send(rand_op(), rand_op());
        drain();
        rdy_mode = 1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
